// File: rtl/multicycle_mips.sv
// Multi-cycle MIPS integer core: FETCH/DECODE/EXEC/MEM/WB sequencing with
// wait-state instruction/data handshakes and a sticky HALT trap.
module multicycle_mips #(
  parameter int unsigned DMEM_AW  = 7,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic [31:0]        IR_addr,
  output logic               IR_req,
  input  logic [31:0]        IR,
  input  logic               IR_ready,
  output logic [DMEM_AW-1:0] A,
  output logic [XLEN-1:0]    Data2Mem,
  input  logic [XLEN-1:0]    ReadDataMem,
  output logic               CEN,
  output logic               WEN,
  output logic               OEN,
  input  logic               mem_ready,
  output logic               halted,
  output logic [2:0]         state_o
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                         OP_LW    = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR  = 6'h08,
                         F_JALR = 6'h09, F_ADD = 6'h20, F_SUB = 6'h22,
                         F_AND = 6'h24, F_OR  = 6'h25, F_SLT = 6'h2A;

  state_t          state;
  logic [31:0]     pc, ir_q;
  logic [XLEN-1:0] regs [32];
  logic [XLEN-1:0] rs_val, rt_val, imm_q, alu_q, mdr;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign shamt = ir_q[10:6];
  assign funct = ir_q[5:0];

  logic [31:0] pc_plus4, br_target, j_target;
  assign pc_plus4  = pc + 32'd4;
  assign br_target = pc_plus4 + {imm_q[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], ir_q[25:0], 2'b00};

  logic legal;
  always_comb begin
    legal = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_SLL, F_SRL, F_JR, F_JALR, F_ADD, F_SUB, F_AND, F_OR, F_SLT: legal = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI,
      OP_LW, OP_SW: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  logic [XLEN-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD:   alu_res = rs_val + rt_val;
          F_SUB:   alu_res = rs_val - rt_val;
          F_AND:   alu_res = rs_val & rt_val;
          F_OR:    alu_res = rs_val | rt_val;
          F_SLT:   alu_res = XLEN'($signed(rs_val) < $signed(rt_val));
          F_SLL:   alu_res = rt_val << shamt;
          F_SRL:   alu_res = rt_val >> shamt;
          default: alu_res = '0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_res = rs_val + imm_q;
      OP_ANDI: alu_res = rs_val & imm_q;
      OP_ORI:  alu_res = rs_val | imm_q;
      OP_SLTI: alu_res = XLEN'($signed(rs_val) < $signed(imm_q));
      default: alu_res = '0;
    endcase
  end

  logic [4:0]      wb_dst;
  logic [XLEN-1:0] wb_data;
  assign wb_dst  = (op == OP_RTYPE) ? rd : rt;
  assign wb_data = (op == OP_LW) ? mdr : alu_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_FETCH;
      pc     <= RESET_PC;
      ir_q   <= '0;
      rs_val <= '0;
      rt_val <= '0;
      imm_q  <= '0;
      alu_q  <= '0;
      mdr    <= '0;
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (IR_ready) begin
            ir_q  <= IR;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          // r0 is never written, so a plain read returns zero for it
          rs_val <= regs[rs];
          rt_val <= regs[rt];
          if (op == OP_ANDI || op == OP_ORI) imm_q <= XLEN'(ir_q[15:0]);
          else                               imm_q <= XLEN'($signed(ir_q[15:0]));
          state  <= legal ? S_EXEC : S_HALT;
        end
        S_EXEC: begin
          alu_q <= alu_res;
          state <= S_WB;
          case (op)
            OP_BEQ, OP_BNE: begin
              pc    <= ((rs_val == rt_val) == (op == OP_BEQ)) ? br_target : pc_plus4;
              state <= S_FETCH;
            end
            OP_J: begin
              pc    <= j_target;
              state <= S_FETCH;
            end
            OP_JAL: begin
              pc       <= j_target;
              regs[31] <= XLEN'(pc_plus4);
              state    <= S_FETCH;
            end
            OP_LW, OP_SW: state <= (alu_res[1:0] != 2'b00) ? S_HALT : S_MEM;
            OP_RTYPE: begin
              if (funct == F_JR || funct == F_JALR) begin
                pc <= rs_val[31:0];
                if (funct == F_JALR && rd != 5'd0) regs[rd] <= XLEN'(pc_plus4);
                state <= S_FETCH;
              end
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (op == OP_LW) begin
              mdr   <= ReadDataMem;
              state <= S_WB;
            end else begin
              pc    <= pc_plus4;
              state <= S_FETCH;
            end
          end
        end
        S_WB: begin
          if (wb_dst != 5'd0) regs[wb_dst] <= wb_data;
          pc    <= pc_plus4;
          state <= S_FETCH;
        end
        default: state <= S_HALT;
      endcase
    end
  end

  // Fetch request is gated by rst so it is low for the whole reset interval
  assign IR_req   = (state == S_FETCH) && !rst;
  assign IR_addr  = pc;
  assign CEN      = (state != S_MEM);
  assign WEN      = !((state == S_MEM) && (op == OP_SW));
  assign OEN      = !((state == S_MEM) && (op == OP_LW));
  assign A        = alu_q[DMEM_AW+1:2];
  assign Data2Mem = rt_val;
  assign halted   = (state == S_HALT);
  assign state_o  = state;
endmodule

// File: tb/tb_multicycle_mips.sv
// Bench for multicycle_mips: ISA-level reference model with per-cycle output
// checking, directed programs, and randomized programs/wait states.
module tb_multicycle_mips;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IR_addr;
  logic        IR_req;
  logic [31:0] IR;
  logic        IR_ready;
  logic [6:0]  A;
  logic [31:0] Data2Mem;
  logic [31:0] ReadDataMem;
  logic        CEN, WEN, OEN;
  logic        mem_ready;
  logic        halted;
  logic [2:0]  state_o;

  multicycle_mips #(.DMEM_AW(7), .RESET_PC(RESET_PC), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .IR_addr(IR_addr), .IR_req(IR_req), .IR(IR),
    .IR_ready(IR_ready), .A(A), .Data2Mem(Data2Mem), .ReadDataMem(ReadDataMem),
    .CEN(CEN), .WEN(WEN), .OEN(OEN), .mem_ready(mem_ready), .halted(halted),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc, mem_cyc, loop_hits, mode, cur;
  bit run_en, ir_rdy, mem_rdy;

  logic [31:0] imem [256];
  logic [31:0] init_dm [128];
  logic [31:0] mem_arr [128];
  int          acc_cyc [256];

  // Architectural reference state
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [128];
  logic [31:0] m_pc, exp_wd;
  logic [6:0]  exp_a;
  bit          m_halted, exp_is_sw;
  int          exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] s, t, d, sh, input logic [5:0] fn);
    return {6'h00, s, t, d, sh, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s, t,
                                        input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic wr(input logic [4:0] idx, input logic [31:0] val);
    if (idx != 5'd0) m_regs[idx] = val;
  endtask

  // Executes one instruction architecturally and queues the expected
  // per-cycle state sequence that follows its fetch.
  task automatic model_step(input logic [31:0] ins);
    logic [5:0]  op, fn;
    logic [4:0]  s, t, d, sh;
    logic [31:0] a, b, simm, zimm, nxt, ea;
    int cls;  // 0 ctrl, 1 alu, 2 sw, 3 lw, 4 illegal, 5 misaligned
    op = ins[31:26]; s = ins[25:21]; t = ins[20:16]; d = ins[15:11];
    sh = ins[10:6];  fn = ins[5:0];
    a = m_regs[s]; b = m_regs[t];
    simm = {{16{ins[15]}}, ins[15:0]};
    zimm = {16'h0000, ins[15:0]};
    nxt = m_pc + 32'd4;
    ea = a + simm;
    cls = 1;
    case (op)
      6'h00: begin
        case (fn)
          6'h20: wr(d, a + b);
          6'h22: wr(d, a - b);
          6'h24: wr(d, a & b);
          6'h25: wr(d, a | b);
          6'h2A: wr(d, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
          6'h00: wr(d, b << sh);
          6'h02: wr(d, b >> sh);
          6'h08: begin m_pc = a; cls = 0; end
          6'h09: begin wr(d, nxt); m_pc = a; cls = 0; end
          default: cls = 4;
        endcase
      end
      6'h08: wr(t, a + simm);
      6'h0C: wr(t, a & zimm);
      6'h0D: wr(t, a | zimm);
      6'h0A: wr(t, ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0);
      6'h04, 6'h05: begin
        m_pc = ((a == b) == (op == 6'h04)) ? nxt + {simm[29:0], 2'b00} : nxt;
        cls = 0;
      end
      6'h02, 6'h03: begin
        if (op == 6'h03) wr(5'd31, nxt);
        m_pc = {nxt[31:28], ins[25:0], 2'b00};
        cls = 0;
      end
      6'h23, 6'h2B: begin
        if (ea[1:0] != 2'b00) cls = 5;
        else begin
          exp_a = ea[8:2];
          exp_is_sw = (op == 6'h2B);
          if (exp_is_sw) begin
            exp_wd = b;
            m_dmem[ea[8:2]] = b;
            cls = 2;
          end else begin
            wr(t, m_dmem[ea[8:2]]);
            cls = 3;
          end
        end
      end
      default: cls = 4;
    endcase
    exp_q.delete();
    exp_q.push_back(1);
    case (cls)
      0: exp_q.push_back(2);
      1: begin exp_q.push_back(2); exp_q.push_back(4); m_pc = nxt; end
      2: begin exp_q.push_back(2); exp_q.push_back(3); m_pc = nxt; end
      3: begin exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4); m_pc = nxt; end
      4: begin exp_q.push_back(5); m_halted = 1'b1; end
      default: begin exp_q.push_back(2); exp_q.push_back(5); m_halted = 1'b1; end
    endcase
  endtask

  always @(negedge clk) begin
    if (run_en) begin
      cyc++;
      chk("state", 32'(state_o), 32'(cur));
      chk1("ir_req", IR_req, cur == 0);
      chk1("halted", halted, cur == 5);
      chk1("cen", CEN, cur != 3);
      chk1("wen", WEN, !(cur == 3 && exp_is_sw));
      chk1("oen", OEN, !(cur == 3 && !exp_is_sw));
      if (cur == 0 || cur == 5) chk("pc", IR_addr, m_pc);
      if (cur == 3) begin
        chk("addr", 32'(A), 32'(exp_a));
        if (exp_is_sw) chk("wdata", Data2Mem, exp_wd);
      end
      mem_cyc = CEN ? 0 : mem_cyc + 1;
      case (mode)
        0: begin
          ir_rdy  = ($urandom_range(0, 3) != 0);
          mem_rdy = ($urandom_range(0, 2) != 0);
        end
        1: begin ir_rdy = 1'b1; mem_rdy = (mem_cyc >= 4); end
        2: begin ir_rdy = 1'b1; mem_rdy = 1'b0; end
        default: begin ir_rdy = 1'b1; mem_rdy = 1'b1; end
      endcase
      IR_ready    = ir_rdy;
      mem_ready   = mem_rdy;
      IR          = ir_rdy ? imem[IR_addr[9:2]] : $urandom();
      ReadDataMem = mem_rdy ? mem_arr[A] : $urandom();
      if (!CEN && !WEN && mem_rdy) mem_arr[A] = Data2Mem;
      if (cur == 0) begin
        if (ir_rdy) begin
          acc_cyc[m_pc[9:2]] = cyc;
          if (m_pc == 32'h10) loop_hits++;
          model_step(imem[m_pc[9:2]]);
          cur = exp_q.pop_front();
        end
      end else if (cur == 3) begin
        if (mem_rdy) cur = (exp_q.size() != 0) ? exp_q.pop_front() : 0;
      end else if (cur != 5) begin
        cur = (exp_q.size() != 0) ? exp_q.pop_front() : 0;
      end
    end else begin
      IR_ready  = 1'b0;
      mem_ready = 1'b0;
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) imem[i] = 32'hFC00_0000;
    for (int i = 0; i < 128; i++) init_dm[i] = $urandom();
  endtask

  task automatic start_prog(input int md);
    run_en = 1'b0;
    rst = 1'b1;
    mode = md;
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < 128; i++) begin
      mem_arr[i] = init_dm[i];
      m_dmem[i]  = init_dm[i];
    end
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    for (int i = 0; i < 256; i++) acc_cyc[i] = 0;
    m_pc = RESET_PC; m_halted = 1'b0; exp_q.delete();
    cur = 0; cyc = 0; mem_cyc = 0; loop_hits = 0;
    rst = 1'b0;
    run_en = 1'b1;
  endtask

  task automatic wait_halt(input int limit);
    int n = 0;
    while (!(m_halted && cur == 5) && n < limit) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    n_chk++;
    if (!(m_halted && cur == 5)) begin
      n_fail++;
      $display("FAIL halt_timeout: no halt after %0d cycles, expected state %0d, required 5", n, cur);
    end
  endtask

  task automatic gen_random();
    int n;
    logic [4:0]  s, t, d;
    logic [15:0] imm;
    clear_prog();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      s = 5'($urandom_range(0, 7));
      t = 5'($urandom_range(0, 7));
      d = 5'($urandom_range(0, 7));
      imm = 16'($urandom());
      case ($urandom_range(0, 14))
        0:  imem[n] = enc_r(s, t, d, 5'd0, 6'h20);
        1:  imem[n] = enc_r(s, t, d, 5'd0, 6'h22);
        2:  imem[n] = enc_r(s, t, d, 5'd0, 6'h24);
        3:  imem[n] = enc_r(s, t, d, 5'd0, 6'h25);
        4:  imem[n] = enc_r(s, t, d, 5'd0, 6'h2A);
        5:  imem[n] = enc_r(5'd0, t, d, imm[4:0], 6'h00);
        6:  imem[n] = enc_r(5'd0, t, d, imm[4:0], 6'h02);
        7:  imem[n] = enc_i(6'h08, s, t, imm);
        8:  imem[n] = enc_i(6'h0C, s, t, imm);
        9:  imem[n] = enc_i(6'h0D, s, t, imm);
        10: imem[n] = enc_i(6'h0A, s, t, imm);
        11: imem[n] = enc_i(6'h23, 5'd0, t, {8'd0, imm[5:0], 2'b00});
        12: imem[n] = enc_i(6'h2B, 5'd0, t, {8'd0, imm[5:0], 2'b00});
        13: imem[n] = enc_i(imm[15] ? 6'h04 : 6'h05, s, t, 16'd1);
        default: imem[n] = enc_j(6'h03, 26'(n + 1));
      endcase
      n++;
    end
    for (int r = 1; r < 32; r++) begin
      imem[n] = enc_i(6'h2B, 5'd0, 5'(r), 16'(384 + 4 * r));
      n++;
    end
    case ($urandom_range(0, 2))
      0: imem[n] = 32'hFC00_0000;
      1: imem[n] = enc_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h3F);
      default: imem[n] = enc_i(6'h23, 5'd0, 5'd1, 16'd2);
    endcase
  endtask

  initial begin
    int n;
    rst = 1'b1; run_en = 1'b0; mode = 0; cur = 0; cyc = 0;
    IR_ready = 1'b0; mem_ready = 1'b0; IR = '0; ReadDataMem = '0;
    exp_is_sw = 1'b0; exp_a = '0; exp_wd = '0;

    #3;
    chk1("rst_ir_req", IR_req, 1'b0);
    chk1("rst_cen", CEN, 1'b1);
    chk1("rst_wen", WEN, 1'b1);
    chk1("rst_oen", OEN, 1'b1);
    chk1("rst_halted", halted, 1'b0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_pc", IR_addr, RESET_PC);

    // ALU, store/load with three wait states, r0 write, misaligned trap
    clear_prog();
    imem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1]  = enc_i(6'h08, 5'd1, 5'd2, 16'hFFF9);
    imem[2]  = enc_r(5'd2, 5'd1, 5'd3, 5'd0, 6'h2A);
    imem[3]  = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
    imem[4]  = enc_i(6'h23, 5'd0, 5'd4, 16'd8);
    imem[5]  = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
    imem[6]  = enc_i(6'h2B, 5'd0, 5'd0, 16'd12);
    imem[7]  = enc_i(6'h2B, 5'd0, 5'd2, 16'd16);
    imem[8]  = enc_i(6'h2B, 5'd0, 5'd3, 16'd20);
    imem[9]  = enc_i(6'h2B, 5'd0, 5'd4, 16'd24);
    imem[10] = enc_i(6'h23, 5'd0, 5'd1, 16'd1);
    start_prog(1);
    wait_halt(2000);
    chk("a_r1", m_regs[1], 32'd5);
    chk("a_r2", m_regs[2], 32'hFFFF_FFFE);
    chk("a_r3", m_regs[3], 32'd1);
    chk("a_r4", m_regs[4], 32'd5);
    chk("a_r0", m_regs[0], 32'd0);
    chk("a_trap_pc", m_pc, 32'h28);
    chk("a_mem_w2", mem_arr[2], 32'd5);
    chk("a_mem_w3", mem_arr[3], 32'd0);
    chk("a_mem_w4", mem_arr[4], 32'hFFFF_FFFE);
    chk("a_lat_alu", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
    chk("a_lat_sw", 32'(acc_cyc[4] - acc_cyc[3]), 32'd7);
    chk("a_lat_lw", 32'(acc_cyc[5] - acc_cyc[4]), 32'd8);

    // Branches, jumps and links, ending in a beq self-loop at 0x10
    clear_prog();
    imem[0]    = enc_i(6'h05, 5'd0, 5'd0, 16'd4);
    imem[1]    = enc_j(6'h02, 26'h8);
    imem[8]    = enc_j(6'h03, 26'h40);
    imem[8'h40] = enc_r(5'd31, 5'd0, 5'd5, 5'd0, 6'h09);
    imem[9]    = enc_i(6'h2B, 5'd0, 5'd5, 16'd0);
    imem[10]   = enc_i(6'h2B, 5'd0, 5'd31, 16'd4);
    imem[11]   = enc_j(6'h02, 26'h4);
    imem[4]    = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
    start_prog(3);
    repeat (120) @(posedge clk);
    chk("b_r31", m_regs[31], 32'h24);
    chk("b_r5", m_regs[5], 32'h104);
    chk("b_loop_pc", m_pc, 32'h10);
    chk("b_lat_bne", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
    chk("b_mem_r5", mem_arr[0], 32'h104);
    chk("b_mem_r31", mem_arr[1], 32'h24);
    chk1("b_loop_hits", loop_hits >= 20, 1'b1);

    // Illegal opcode at the reset PC
    clear_prog();
    start_prog(0);
    wait_halt(200);
    #1;
    chk1("c_halted", halted, 1'b1);
    chk("c_halt_pc", IR_addr, RESET_PC);

    // Asynchronous reset while a store is stalled in MEM
    clear_prog();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
    start_prog(2);
    n = 0;
    while (CEN !== 1'b0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk1("e_in_mem", CEN, 1'b0);
    @(posedge clk);
    #3;
    run_en = 1'b0;
    rst = 1'b1;
    #1;
    chk1("e_rst_cen", CEN, 1'b1);
    chk1("e_rst_wen", WEN, 1'b1);
    chk1("e_rst_oen", OEN, 1'b1);
    chk1("e_rst_ir_req", IR_req, 1'b0);
    chk1("e_rst_halted", halted, 1'b0);
    chk("e_rst_state", 32'(state_o), 32'd0);
    chk("e_rst_pc", IR_addr, RESET_PC);
    chk("e_no_write", mem_arr[2], init_dm[2]);

    for (int p = 0; p < 6; p++) begin
      gen_random();
      start_prog((p % 2 == 0) ? 0 : 3);
      wait_halt(4000);
      for (int i = 0; i < 128; i++) chk("rand_dmem", mem_arr[i], m_dmem[i]);
    end

    run_en = 1'b0;
    rst = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
